// File: rtl/ddr_rw_arbiter_pkg.sv
// Shared encodings for the DDR read/write command arbiter: FSM states,
// owner codes and the last-grant marker used by round-robin.
package ddr_rw_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CMD  = ST_CMD,
    BUSY = ST_BUSY
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_RD   = 2'd1;
  localparam logic [1:0] OWN_WR   = 2'd2;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_e;

endpackage

// File: rtl/ddr_req_slot.sv
// One pending-request slot: pending flag, address/length capture and
// overflow detection for a requester that issues single-cycle pulses.
module ddr_req_slot #(
  parameter int ADDR_WIDTH = 27,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  clr_i,
  output logic                  pend_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [LEN_WIDTH-1:0]  len_o,
  output logic                  ovf_o
);

  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  capture;

  // A request landing on the clearing cycle refills the slot instead of overflowing.
  assign capture = req_i & (~pend_q | clr_i);
  assign pend_d  = req_i | (pend_q & ~clr_i);
  assign ovf_o   = req_i & pend_q & ~clr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= 1'b0;
    else         pend_q <= pend_d;
  end

  always_ff @(posedge clk_i) begin
    if (capture) begin
      addr_q <= addr_i;
      len_q  <= len_i;
    end
  end

  assign pend_o = pend_q;
  assign addr_o = addr_q;
  assign len_o  = len_q;

endmodule

// File: rtl/ddr_rw_arbiter.sv
// Arbitrates one DDR command port between line-fetch reads and line-store
// writes. Define RD_PRIORITY_EN to make a pending read always win in IDLE.
module ddr_rw_arbiter
  import ddr_rw_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 27,
  parameter int LEN_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_WIDTH    = 13
) (
  input  logic                  ddr_clk,
  input  logic                  ddr_rstn,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  output logic                  rd_rrdy,
  output logic                  rd_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [LEN_WIDTH-1:0]  wr_len,
  output logic                  wr_rdy,
  output logic                  wr_done,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_wr,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  output logic [LEN_WIDTH-1:0]  mem_cmd_len,
  input  logic                  mem_done,
  output logic [1:0]            owner,
  output logic [1:0]            err_ovf,
  output logic                  err_timeout
);

  state_e                state_q;
  grant_e                last_grant_q;
  logic [1:0]            owner_q;
  logic                  valid_q, cmd_wr_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [LEN_WIDTH-1:0]  cmd_len_q;
  logic                  rd_rrdy_q, rd_done_q, wr_rdy_q, wr_done_q;
  logic [1:0]            err_ovf_q;
  logic                  err_to_q;
  logic [TO_WIDTH-1:0]   to_cnt_q;

  logic                  rd_pend, wr_pend, rd_ovf, wr_ovf;
  logic [ADDR_WIDTH-1:0] rd_addr_s, wr_addr_s;
  logic [LEN_WIDTH-1:0]  rd_len_s, wr_len_s;
  logic                  hs, rd_clr, wr_clr, gnt_wr, to_hit;

  assign hs     = (state_q == CMD) & valid_q & mem_cmd_ready;
  assign rd_clr = hs & (owner_q == OWN_RD);
  assign wr_clr = hs & (owner_q == OWN_WR);
  assign to_hit = (to_cnt_q == TO_WIDTH'(TIMEOUT_CYC - 1));

  ddr_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_rd_slot (
    .clk_i(ddr_clk), .rst_ni(ddr_rstn), .req_i(rd_req), .addr_i(rd_addr),
    .len_i(rd_len), .clr_i(rd_clr), .pend_o(rd_pend), .addr_o(rd_addr_s),
    .len_o(rd_len_s), .ovf_o(rd_ovf)
  );

  ddr_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_wr_slot (
    .clk_i(ddr_clk), .rst_ni(ddr_rstn), .req_i(wr_req), .addr_i(wr_addr),
    .len_i(wr_len), .clr_i(wr_clr), .pend_o(wr_pend), .addr_o(wr_addr_s),
    .len_o(wr_len_s), .ovf_o(wr_ovf)
  );

  always_comb begin
    gnt_wr = 1'b0;
`ifdef RD_PRIORITY_EN
    gnt_wr = ~rd_pend;
`else
    gnt_wr = wr_pend & (~rd_pend | (last_grant_q == GNT_RD));
`endif
  end

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_WR;
      owner_q      <= OWN_NONE;
      valid_q      <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      rd_rrdy_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      wr_rdy_q     <= 1'b0;
      wr_done_q    <= 1'b0;
      err_ovf_q    <= 2'b00;
      err_to_q     <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      rd_rrdy_q <= 1'b0;
      rd_done_q <= 1'b0;
      wr_rdy_q  <= 1'b0;
      wr_done_q <= 1'b0;
      err_ovf_q <= err_ovf_q | {wr_ovf, rd_ovf};
      case (state_q)
        IDLE: begin
          if (rd_pend | wr_pend) begin
            state_q    <= CMD;
            valid_q    <= 1'b1;
            cmd_wr_q   <= gnt_wr;
            cmd_addr_q <= gnt_wr ? wr_addr_s : rd_addr_s;
            cmd_len_q  <= gnt_wr ? wr_len_s : rd_len_s;
            owner_q    <= gnt_wr ? OWN_WR : OWN_RD;
            to_cnt_q   <= '0;
          end
        end
        CMD: begin
          if (mem_cmd_ready) begin
            valid_q  <= 1'b0;
            state_q  <= BUSY;
            to_cnt_q <= '0;
            if (owner_q == OWN_WR) begin
              wr_rdy_q     <= 1'b1;
              last_grant_q <= GNT_WR;
            end else begin
              rd_rrdy_q    <= 1'b1;
              last_grant_q <= GNT_RD;
            end
          end else if (to_hit) begin
            // Slot stays pending, so the command is re-offered from IDLE.
            err_to_q <= 1'b1;
            valid_q  <= 1'b0;
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_WIDTH'(1);
          end
        end
        BUSY: begin
          if (mem_done) begin
            rd_done_q <= (owner_q == OWN_RD);
            wr_done_q <= (owner_q == OWN_WR);
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
          end else if (to_hit) begin
            err_to_q <= 1'b1;
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_cmd_valid = valid_q;
  assign mem_cmd_wr    = cmd_wr_q;
  assign mem_cmd_addr  = cmd_addr_q;
  assign mem_cmd_len   = cmd_len_q;
  assign rd_rrdy       = rd_rrdy_q;
  assign rd_done       = rd_done_q;
  assign wr_rdy        = wr_rdy_q;
  assign wr_done       = wr_done_q;
  assign owner         = owner_q;
  assign err_ovf       = err_ovf_q;
  assign err_timeout   = err_to_q;

endmodule
